// File: rtl/disp_clk_pkg.sv
// Shared types and default timing for the display-clock sequencer.
// Modes map directly onto the clock generator's select encoding.
package disp_clk_pkg;

  typedef enum logic [1:0] {
    VGA  = 2'b00,
    XGA  = 2'b01,
    SVGA = 2'b10,
    SXGA = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    QUIESCE   = 3'd1,
    SETTLE    = 3'd2,
    WAIT_LOCK = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  localparam int DEF_QUIESCE_CYC = 16;
  localparam int DEF_SETTLE_CYC  = 64;
  localparam int DEF_TIMEOUT_CYC = 4096;
  localparam int DEF_CNT_W       = 13;

endpackage

// File: rtl/disp_clk_seq_cnt.sv
// Saturating wait counter with terminal-count compare
// against a limit that the sequencer switches per state.
module seq_wait_cnt #(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == limit - 1'b1);

endmodule

// File: rtl/disp_clk_seq.sv
// Display-clock switch sequencer: holds the display in reset
// across a clock-mux change, waits for settle and PLL lock.
module disp_clk_seq
  import disp_clk_pkg::*;
#(
  parameter logic [1:0] INIT_MODE   = 2'b00,
  parameter int         QUIESCE_CYC = DEF_QUIESCE_CYC,
  parameter int         SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int         CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_mode,
  output logic       req_ready,
  input  logic       pll_locked,
  output logic [1:0] clk_sel,
  output logic       disp_rst_n,
  output logic [1:0] cur_mode,
  output logic       busy,
  output logic       done,
  output logic       lock_err
);

  localparam logic [CNT_W-1:0] Q_LIM = CNT_W'(QUIESCE_CYC);
  localparam logic [CNT_W-1:0] S_LIM = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] T_LIM = CNT_W'(TIMEOUT_CYC);

  state_t           state;
  mode_t            pend;
  logic             lk_meta;
  logic             lk;
  logic             tc;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] limit;

  // pll_locked is asynchronous to clk
  always_ff @(posedge clk) begin
    lk_meta <= pll_locked;
    lk      <= lk_meta;
  end

  always_comb begin
    cnt_clr = 1'b1;
    cnt_en  = 1'b0;
    limit   = Q_LIM;
    unique case (1'b1)
      (state == QUIESCE): begin
        limit   = Q_LIM;
        cnt_en  = 1'b1;
        cnt_clr = tc;
      end
      (state == SETTLE): begin
        limit   = S_LIM;
        cnt_en  = 1'b1;
        cnt_clr = tc;
      end
      (state == WAIT_LOCK): begin
        limit   = T_LIM;
        cnt_en  = 1'b1;
        cnt_clr = tc || lk;
      end
      default: ;
    endcase
  end

  seq_wait_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (limit),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SETTLE;
      pend       <= mode_t'(INIT_MODE);
      clk_sel    <= INIT_MODE;
      cur_mode   <= INIT_MODE;
      disp_rst_n <= 1'b0;
      req_ready  <= 1'b0;
      busy       <= 1'b1;
      done       <= 1'b0;
      lock_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (req_mode == cur_mode) begin
              done <= 1'b1;
            end else begin
              pend       <= mode_t'(req_mode);
              disp_rst_n <= 1'b0;
              busy       <= 1'b1;
              state      <= QUIESCE;
            end
          end
        end
        QUIESCE: begin
          if (tc) begin
            clk_sel  <= pend;
            cur_mode <= pend;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (tc) state <= WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lk) begin
            lock_err <= 1'b0;
            state    <= RELEASE;
          end else if (tc) begin
            // fail open so the display is never left frozen
            lock_err <= 1'b1;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          disp_rst_n <= 1'b1;
          done       <= 1'b1;
          busy       <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= SETTLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_clk_seq.sv
// Directed bench for disp_clk_seq; edge counts are taken
// from the accept edge (or first edge out of reset).
module tb_disp_clk_seq;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_mode;
  logic       req_ready;
  logic       pll_locked;
  logic [1:0] clk_sel;
  logic       disp_rst_n;
  logic [1:0] cur_mode;
  logic       busy;
  logic       done;
  logic       lock_err;

  int vectors;
  int miscompares;
  int done_at;
  int sel_at;
  int rst_hi;
  int rdy_bad;

  disp_clk_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_mode   (req_mode),
    .req_ready  (req_ready),
    .pll_locked (pll_locked),
    .clk_sel    (clk_sel),
    .disp_rst_n (disp_rst_n),
    .cur_mode   (cur_mode),
    .busy       (busy),
    .done       (done),
    .lock_err   (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [1:0] m);
    req_valid = 1'b1;
    req_mode  = m;
    step();
    req_valid = 1'b0;
  endtask

  // Step until done; note the edge where clk_sel changed,
  // edges where disp_rst_n was high early, and any
  // req_ready while hammering requests.
  task automatic run_seq(input int bound,
                         input bit hammer,
                         output int d_at,
                         output int s_at,
                         output int hi,
                         output int rb);
    logic [1:0] s0;
    s0   = clk_sel;
    d_at = -1;
    s_at = -1;
    hi   = 0;
    rb   = 0;
    for (int k = 1; k <= bound; k++) begin
      if (hammer) begin
        req_valid = 1'b1;
        req_mode  = 2'(k);
      end
      step();
      if (s_at < 0 && clk_sel !== s0) s_at = k;
      if (done === 1'b1) begin
        d_at = k;
        req_valid = 1'b0;
        break;
      end
      if (disp_rst_n !== 1'b0) hi++;
      if (hammer && req_ready !== 1'b0) rb++;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_mode    = 2'b00;
    pll_locked  = 1'b1;

    // power-up
    repeat (5) step();
    chk("rst_disp_rst_n", 32'(disp_rst_n), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_clk_sel", 32'(clk_sel), 0);
    chk("rst_cur_mode", 32'(cur_mode), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_lock_err", 32'(lock_err), 0);
    rst_n = 1'b1;
    run_seq(200, 0, done_at, sel_at, rst_hi, rdy_bad);
    chk("pwr_done_edge", 32'(done_at), 66);
    chk("pwr_rst_early", 32'(rst_hi), 0);
    chk("pwr_disp_rst_n", 32'(disp_rst_n), 1);
    chk("pwr_clk_sel", 32'(clk_sel), 0);
    chk("pwr_req_ready", 32'(req_ready), 1);
    step();
    chk("pwr_done_pulse", 32'(done), 0);

    // VGA -> SXGA with lock present
    accept(2'b11);
    chk("sx_req_ready", 32'(req_ready), 0);
    chk("sx_busy", 32'(busy), 1);
    chk("sx_disp_rst_n", 32'(disp_rst_n), 0);
    run_seq(200, 0, done_at, sel_at, rst_hi, rdy_bad);
    chk("sx_sel_edge", 32'(sel_at), 16);
    chk("sx_done_edge", 32'(done_at), 82);
    chk("sx_rst_early", 32'(rst_hi), 0);
    chk("sx_clk_sel", 32'(clk_sel), 3);
    chk("sx_cur_mode", 32'(cur_mode), 3);
    chk("sx_lock_err", 32'(lock_err), 0);
    chk("sx_disp_rst_n_up", 32'(disp_rst_n), 1);
    step();

    // SXGA -> SVGA while requests keep changing
    accept(2'b10);
    run_seq(200, 1, done_at, sel_at, rst_hi, rdy_bad);
    chk("busy_ready_low", 32'(rdy_bad), 0);
    chk("busy_done_edge", 32'(done_at), 82);
    chk("busy_cur_mode", 32'(cur_mode), 2);
    chk("busy_clk_sel", 32'(clk_sel), 2);
    step();
    chk("busy_idle_ready", 32'(req_ready), 1);
    chk("busy_no_reaccept", 32'(busy), 0);

    // same-mode request
    accept(2'b10);
    chk("same_done", 32'(done), 1);
    chk("same_disp_rst_n", 32'(disp_rst_n), 1);
    chk("same_clk_sel", 32'(clk_sel), 2);
    chk("same_ready_low", 32'(req_ready), 0);
    chk("same_busy", 32'(busy), 0);
    step();
    chk("same_done_clr", 32'(done), 0);
    chk("same_ready_back", 32'(req_ready), 1);

    // SVGA -> XGA with no lock: timeout
    pll_locked = 1'b0;
    accept(2'b01);
    run_seq(5000, 0, done_at, sel_at, rst_hi, rdy_bad);
    chk("to_done_edge", 32'(done_at), 4177);
    chk("to_lock_err", 32'(lock_err), 1);
    chk("to_disp_rst_n", 32'(disp_rst_n), 1);
    chk("to_clk_sel", 32'(clk_sel), 1);
    step();

    // same-mode request keeps lock_err
    accept(2'b01);
    chk("to_same_done", 32'(done), 1);
    chk("to_same_lock_err", 32'(lock_err), 1);
    step();

    // successful switch clears lock_err
    pll_locked = 1'b1;
    accept(2'b00);
    run_seq(200, 0, done_at, sel_at, rst_hi, rdy_bad);
    chk("clr_done_edge", 32'(done_at), 82);
    chk("clr_lock_err", 32'(lock_err), 0);
    chk("clr_clk_sel", 32'(clk_sel), 0);
    step();

    // reset during SETTLE
    accept(2'b11);
    repeat (19) step();
    chk("mid_clk_sel", 32'(clk_sel), 3);
    rst_n = 1'b0;
    step();
    chk("mid_rst_clk_sel", 32'(clk_sel), 0);
    chk("mid_rst_cur_mode", 32'(cur_mode), 0);
    chk("mid_rst_disp", 32'(disp_rst_n), 0);
    chk("mid_rst_busy", 32'(busy), 1);
    rst_n = 1'b1;
    run_seq(200, 0, done_at, sel_at, rst_hi, rdy_bad);
    chk("mid_done_edge", 32'(done_at), 66);
    chk("mid_clk_sel_end", 32'(clk_sel), 0);
    chk("mid_disp_end", 32'(disp_rst_n), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
